// File: rtl/btn_event_arb.sv
// Round-robin arbiter turning per-button press pulses into a valid/ready event stream.
// Define BTN_EVENT_ARB_FIFO_EN for a 4-deep ID FIFO output stage; otherwise a single output register is used.
module btn_event_arb #(
  parameter int N_BTN = 4,
  parameter int ID_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_BTN-1:0]  tick_in,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [ID_W-1:0]   evt_id,
  output logic [N_BTN-1:0]  pending,
  output logic [7:0]        drop_cnt
);

  logic [N_BTN-1:0] pending_r;
  logic [ID_W-1:0]  ptr_r;
  logic [7:0]       drop_cnt_r;
  logic             evt_valid_r;
  logic [ID_W-1:0]  evt_id_r;

  logic             transfer_s;
  logic             grant_ok_s;
  logic             grant_any_s;
  logic [ID_W-1:0]  grant_id_s;
  logic [N_BTN-1:0] grant_mask_s;
  logic [N_BTN-1:0] pending_nxt_s;
  logic [ID_W-1:0]  ptr_nxt_s;
  logic [3:0]       drop_n_s;
  logic [8:0]       drop_sum_s;
  logic [7:0]       drop_nxt_s;

  assign transfer_s = evt_valid_r & evt_ready;

`ifdef BTN_EVENT_ARB_FIFO_EN
  logic [ID_W-1:0]  fifo_q_r   [0:3];
  logic [2:0]       fifo_cnt_r;
  logic [ID_W-1:0]  fifo_nxt_s [0:3];
  logic [2:0]       cnt_mid_s;
  logic [2:0]       cnt_nxt_s;

  // A full FIFO can still take a grant when its head leaves on the same edge.
  assign grant_ok_s = (fifo_cnt_r != 3'd4) || transfer_s;
`else
  assign grant_ok_s = !evt_valid_r || transfer_s;
`endif

  // Round-robin search of the registered pending flags starting at ptr.
  always_comb begin
    int idx;
    grant_any_s = 1'b0;
    grant_id_s  = '0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = int'(ptr_r) + k;
      if (idx >= N_BTN) begin
        idx = idx - N_BTN;
      end else begin
        idx = idx;
      end
      if (!grant_any_s && pending_r[idx]) begin
        grant_any_s = 1'b1;
        grant_id_s  = ID_W'(idx);
      end else begin
        grant_any_s = grant_any_s;
      end
    end
    if (!grant_ok_s) begin
      grant_any_s = 1'b0;
    end else begin
      grant_any_s = grant_any_s;
    end
  end

  // Pending update, drop accounting and pointer advance.
  always_comb begin
    drop_n_s = 4'd0;
    for (int i = 0; i < N_BTN; i++) begin
      grant_mask_s[i] = grant_any_s && (grant_id_s == ID_W'(i));
      // A tick on a channel being granted in this cycle re-arms it without a drop.
      pending_nxt_s[i] = tick_in[i] | (pending_r[i] & ~grant_mask_s[i]);
      drop_n_s = drop_n_s + 4'(tick_in[i] & pending_r[i] & ~grant_mask_s[i]);
    end
    drop_sum_s = {1'b0, drop_cnt_r} + {5'd0, drop_n_s};
    if (drop_sum_s > 9'd255) begin
      drop_nxt_s = 8'd255;
    end else begin
      drop_nxt_s = drop_sum_s[7:0];
    end
    if (!grant_any_s) begin
      ptr_nxt_s = ptr_r;
    end else if (grant_id_s == ID_W'(N_BTN - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = grant_id_s + ID_W'(1);
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_r  <= '0;
      ptr_r      <= '0;
      drop_cnt_r <= 8'd0;
    end else begin
      pending_r  <= pending_nxt_s;
      ptr_r      <= ptr_nxt_s;
      drop_cnt_r <= drop_nxt_s;
    end
  end

`ifdef BTN_EVENT_ARB_FIFO_EN
  // FIFO next state: pop shifts toward the head, push lands after the survivors.
  always_comb begin
    cnt_mid_s = fifo_cnt_r - {2'd0, transfer_s};
    for (int j = 0; j < 3; j++) begin
      fifo_nxt_s[j] = transfer_s ? fifo_q_r[j+1] : fifo_q_r[j];
    end
    fifo_nxt_s[3] = fifo_q_r[3];
    for (int j = 0; j < 4; j++) begin
      if (grant_any_s && (cnt_mid_s == 3'(j))) begin
        fifo_nxt_s[j] = grant_id_s;
      end else begin
        fifo_nxt_s[j] = fifo_nxt_s[j];
      end
    end
    cnt_nxt_s = cnt_mid_s + {2'd0, grant_any_s};
  end

  // FIFO storage with a registered head and valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int j = 0; j < 4; j++) begin
        fifo_q_r[j] <= '0;
      end
      fifo_cnt_r  <= 3'd0;
      evt_valid_r <= 1'b0;
      evt_id_r    <= '0;
    end else begin
      for (int j = 0; j < 4; j++) begin
        fifo_q_r[j] <= fifo_nxt_s[j];
      end
      fifo_cnt_r  <= cnt_nxt_s;
      evt_valid_r <= (cnt_nxt_s != 3'd0);
      evt_id_r    <= fifo_nxt_s[0];
    end
  end
`else
  // Single output register: load on grant, empty on an unreplaced transfer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      evt_valid_r <= 1'b0;
      evt_id_r    <= '0;
    end else if (grant_any_s) begin
      evt_valid_r <= 1'b1;
      evt_id_r    <= grant_id_s;
    end else if (transfer_s) begin
      evt_valid_r <= 1'b0;
      evt_id_r    <= evt_id_r;
    end else begin
      evt_valid_r <= evt_valid_r;
      evt_id_r    <= evt_id_r;
    end
  end
`endif

  assign evt_valid = evt_valid_r;
  assign evt_id    = evt_id_r;
  assign pending   = pending_r;
  assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_btn_event_arb.sv
// Bench for btn_event_arb: directed scenarios plus random traffic against a queue-based reference model.
module tb_btn_event_arb;
  localparam int N = 4;
`ifdef BTN_EVENT_ARB_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] tick_in = '0;
  logic         evt_valid;
  logic         evt_ready = 1'b0;
  logic [1:0]   evt_id;
  logic [N-1:0] pending;
  logic [7:0]   drop_cnt;

  btn_event_arb #(.N_BTN(N), .ID_W(2)) dut (
    .clk(clk), .reset(reset), .tick_in(tick_in), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_id(evt_id), .pending(pending), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  bit m_pend [N];
  int m_ptr;
  int m_drop;
  int m_q [$];
  int obs_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [N-1:0] t, input logic r, input logic rst);
    int g;
    int nd;
    bit pop;
    bit np [N];
    if (!rst) begin
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      m_ptr = 0;
      m_drop = 0;
      m_q.delete();
    end else begin
      pop = (m_q.size() > 0) && r;
      g = -1;
      if ((m_q.size() - int'(pop)) < CAP) begin
        for (int k = 0; k < N; k++)
          if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      nd = 0;
      for (int i = 0; i < N; i++) begin
        if (t[i] && m_pend[i] && i != g) nd++;
        np[i] = t[i] || (m_pend[i] && i != g);
      end
      for (int i = 0; i < N; i++) m_pend[i] = np[i];
      m_drop = (m_drop + nd > 255) ? 255 : m_drop + nd;
      if (pop) void'(m_q.pop_front());
      if (g >= 0) begin
        m_q.push_back(g);
        m_ptr = (g + 1) % N;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] t, input logic r);
    logic [N-1:0] ep;
    tick_in = t;
    evt_ready = r;
    if (reset && evt_valid && r) obs_log.push_back(int'(evt_id));
    @(posedge clk);
    model(t, r, reset);
    #1;
    for (int i = 0; i < N; i++) ep[i] = m_pend[i];
    chk("pending", 32'(pending), 32'(ep));
    chk("evt_valid", 32'(evt_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) chk("evt_id", 32'(evt_id), 32'(m_q[0]));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic chk_log(input string tag, input int exp [$]);
    chk({tag, "_len"}, 32'(obs_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk(tag, (i < obs_log.size()) ? 32'(obs_log[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
  endtask

  initial begin
    // Reset with every channel ticking
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(4'b1111, 1'b1);
    reset = 1'b1;
    step(4'b0000, 1'b1);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);

    // Fairness from ptr=0
    obs_log.delete();
    step(4'b1111, 1'b1);
    for (int i = 0; i < 6; i++) step(4'b0000, 1'b1);
    chk_log("fair_order", '{0, 1, 2, 3});

    // Single press on channel 2 leaves ptr at 3
    obs_log.delete();
    step(4'b0100, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b1);
    chk_log("single", '{2});
    chk("single_pending", 32'(pending), 32'd0);

    // Round-robin starting at ptr=3
    obs_log.delete();
    step(4'b1111, 1'b1);
    for (int i = 0; i < 6; i++) step(4'b0000, 1'b1);
    chk_log("rr_ptr3", '{3, 0, 1, 2});

    // Same-cycle set and grant of channel 0
    obs_log.delete();
    step(4'b0001, 1'b1);
    step(4'b0001, 1'b1);
    chk("setclr_pending0", 32'(pending[0]), 32'd1);
    chk("setclr_drop", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b1);
    chk_log("setclr", '{0, 0});

`ifndef BTN_EVENT_ARB_FIFO_EN
    // Stall and drop with the single output register
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0010, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0010, 1'b0);
    chk("stall_drop", 32'(drop_cnt), 32'd3);
    chk("stall_id", 32'(evt_id), 32'd1);
    chk("stall_pending", 32'(pending), 32'b0010);
`else
    // FIFO fill under back-pressure, then drain in order
    obs_log.delete();
    step(4'b0001, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b0001, 1'b0);
    step(4'b0010, 1'b0);
    chk("fifo_pending", 32'(pending), 32'b0011);
    for (int i = 0; i < 10; i++) step(4'b0000, 1'b1);
    chk_log("fifo_order", '{0, 1, 2, 3, 0, 1});
    chk("fifo_drop", 32'(drop_cnt), 32'd0);
`endif

    // Saturation: 300 colliding ticks on one channel, then multi-channel clamping
    for (int i = 0; i < 300; i++) step(4'b0010, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b1111, 1'b0);
    chk("sat_drop", 32'(drop_cnt), 32'd255);

    // Reset mid-transfer discards the presented event
    reset = 1'b0;
    step(4'b1111, 1'b1);
    reset = 1'b1;
    step(4'b0000, 1'b1);
    chk("midrst_valid", 32'(evt_valid), 32'd0);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 59) != 0);
      step(4'($urandom) & 4'($urandom), 1'($urandom_range(0, 2) != 0));
    end
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
